// File: rtl/i2f_iter_pkg.sv
// Shared custom-float format definitions.
// Float word layout: {s, e[EXP-1:0], m[MAN-1:0]}, value = (-1)^s * m * 2^e,
// with e in two's complement and m an unsigned magnitude.
// The float-to-integer unit and the float ALU use these same constants.
package i2f_iter_pkg;

  localparam int MAN = 23;            // mantissa (magnitude) bits
  localparam int EXP = 8;             // exponent bits, two's complement
  localparam int W   = MAN + EXP + 1; // full word width

  // Field slices of the float word
  localparam int SIGN_IDX = W - 1;
  localparam int EXP_HI   = W - 2;
  localparam int EXP_LO   = MAN;
  localparam int MAN_HI   = MAN - 1;
  localparam int MAN_LO   = 0;

  // Magnitude of a signed word, returned unsigned at full width so that the
  // most negative input (-2^(W-1)) is representable.
  function automatic logic [W-1:0] abs_word(input logic [W-1:0] x);
    return x[SIGN_IDX] ? (~x + W'(1)) : x;
  endfunction

  // Assemble a float word from its fields.
  function automatic logic [W-1:0] pack_float(input logic s,
                                              input logic [EXP-1:0] e,
                                              input logic [MAN-1:0] m);
    logic [W-1:0] f;
    f                  = '0;
    f[SIGN_IDX]        = s;
    f[EXP_HI:EXP_LO]   = e;
    f[MAN_HI:MAN_LO]   = m;
    return f;
  endfunction

endpackage

// File: rtl/i2f_iter_if.sv
// Handshake bundle of the iterative integer-to-float converter.
//   in_valid/in_ready/in    : signed integer operand, valid/ready
//   out_valid/out_ready/out : float word result, valid/ready
// master = producer of operands / consumer of results, slave = converter.
interface i2f_iter_if;
  import i2f_iter_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/i2f_iter.sv
// Iterative integer-to-float converter.
// Accepts a signed W-bit integer and normalises its magnitude with one shift
// per cycle until mag[MAN-1] is the leading one, tracking the exponent.
// Oversized magnitudes are shifted right with truncation toward zero.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : i2f_iter_if slave (operand in, float word out, valid/ready each)
module i2f_iter
  import i2f_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  i2f_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           sign_q;
  logic [W-1:0]   mag_q;
  logic [EXP-1:0] exp_q;
  logic [W-1:0]   out_q;

  logic mag_zero;  // nothing to normalise: result is +0
  logic mag_big;   // magnitude does not fit in MAN bits: shift right
  logic mag_low;   // leading one below mag[MAN-1]: shift left
  logic norm_ok;   // mantissa is normalised and can be emitted

  always_comb begin
    mag_zero = (mag_q == '0);
    mag_big  = |mag_q[W-1:MAN];
    mag_low  = ~mag_q[MAN-1];
    norm_ok  = ~mag_zero & ~mag_big & ~mag_low;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)           state_nxt = NORM;
      NORM:    if (mag_zero || norm_ok)    state_nxt = DONE;
      DONE:    if (bus.out_ready)          state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Datapath: one shift register, an exponent up/down counter and the
  // result register. out_q holds its value through IDLE until overwritten.
  // NOTE: all state here is cleared by the asynchronous reset so an aborted
  // conversion leaves no partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      exp_q  <= '0;
      out_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.in[SIGN_IDX];
            mag_q  <= abs_word(bus.in);
            exp_q  <= '0;
          end
        end
        NORM: begin
          if (mag_zero) begin
            out_q <= '0;                        // zero is always +0
          end else if (mag_big) begin
            mag_q <= mag_q >> 1;                // LSB dropped, no rounding
            exp_q <= exp_q + EXP'(1);
          end else if (mag_low) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EXP'(1);
          end else begin
            out_q <= pack_float(sign_q, exp_q, mag_q[MAN-1:0]);
          end
        end
        default: ;                              // DONE: hold everything
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;

endmodule
